// File: rtl/axi_mux_pkg.sv
// Shared definitions for the AXI slave-side read/write muxes: response codes,
// read-path FSM states and default address region decode constants.
package axi_mux_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2,
        ERR   = 2'd3
    } rd_state_e;

    // Region defaults: a match is (addr & MASK) == BASE
    localparam logic [31:0] S0_BASE_DEF = 32'h0000_0000;
    localparam logic [31:0] S0_MASK_DEF = 32'hF000_0000;
    localparam logic [31:0] S1_BASE_DEF = 32'h1FD0_0000;
    localparam logic [31:0] S1_MASK_DEF = 32'hFFFF_0000;

endpackage

// File: rtl/axi_r_decerr_gen.sv
// Internal DECERR responder: produces ARLEN+1 R beats with RRESP=DECERR for an
// unmapped read, counting handshakes with an 8-bit beat counter.
module axi_r_decerr_gen
    import axi_mux_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start,
    input  logic [ID_WIDTH-1:0]   id,
    input  logic [7:0]            len,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic [USER_WIDTH-1:0] ruser,
    output logic                  rvalid,
    output logic                  done
);

    logic                busy_q;
    logic [7:0]          cnt_q;
    logic [7:0]          len_q;
    logic [ID_WIDTH-1:0] id_q;

    // cnt stops at len_q, so a 256-beat burst never needs to wrap
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            len_q  <= '0;
            id_q   <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            len_q  <= len;
            id_q   <= id;
        end else if (busy_q && rready) begin
            if (cnt_q == len_q) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign rvalid = busy_q;
    assign rlast  = busy_q && (cnt_q == len_q);
    assign rid    = busy_q ? id_q : '0;
    assign rdata  = '0;
    assign rresp  = busy_q ? RESP_DECERR : RESP_OKAY;
    assign ruser  = '0;
    assign done   = busy_q && rready && rlast;

endmodule

// File: rtl/axi_slave_mux_r.sv
// AXI read-channel slave mux: decodes AR into s0 (memory) / s1 (MMIO) or an
// internal DECERR burst, one read outstanding. Optional AXI_MUX_R_STATS_EN adds counters.
module axi_slave_mux_r
    import axi_mux_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1,
    parameter logic [ADDR_WIDTH-1:0] S0_BASE = ADDR_WIDTH'(S0_BASE_DEF),
    parameter logic [ADDR_WIDTH-1:0] S0_MASK = ADDR_WIDTH'(S0_MASK_DEF),
    parameter logic [ADDR_WIDTH-1:0] S1_BASE = ADDR_WIDTH'(S1_BASE_DEF),
    parameter logic [ADDR_WIDTH-1:0] S1_MASK = ADDR_WIDTH'(S1_MASK_DEF)
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ID_WIDTH-1:0]   m_ARID,
    input  logic [ADDR_WIDTH-1:0] m_ARADDR,
    input  logic [7:0]            m_ARLEN,
    input  logic [2:0]            m_ARSIZE,
    input  logic [1:0]            m_ARBURST,
    input  logic [USER_WIDTH-1:0] m_ARUSER,
    input  logic                  m_ARVALID,
    output logic                  m_ARREADY,
    output logic [ID_WIDTH-1:0]   m_RID,
    output logic [DATA_WIDTH-1:0] m_RDATA,
    output logic [1:0]            m_RRESP,
    output logic                  m_RLAST,
    output logic [USER_WIDTH-1:0] m_RUSER,
    output logic                  m_RVALID,
    input  logic                  m_RREADY,
    output logic [ID_WIDTH-1:0]   s0_ARID,
    output logic [ADDR_WIDTH-1:0] s0_ARADDR,
    output logic [7:0]            s0_ARLEN,
    output logic [2:0]            s0_ARSIZE,
    output logic [1:0]            s0_ARBURST,
    output logic [USER_WIDTH-1:0] s0_ARUSER,
    output logic                  s0_ARVALID,
    input  logic                  s0_ARREADY,
    input  logic [ID_WIDTH-1:0]   s0_RID,
    input  logic [DATA_WIDTH-1:0] s0_RDATA,
    input  logic [1:0]            s0_RRESP,
    input  logic                  s0_RLAST,
    input  logic [USER_WIDTH-1:0] s0_RUSER,
    input  logic                  s0_RVALID,
    output logic                  s0_RREADY,
    output logic [ID_WIDTH-1:0]   s1_ARID,
    output logic [ADDR_WIDTH-1:0] s1_ARADDR,
    output logic [7:0]            s1_ARLEN,
    output logic [2:0]            s1_ARSIZE,
    output logic [1:0]            s1_ARBURST,
    output logic [USER_WIDTH-1:0] s1_ARUSER,
    output logic                  s1_ARVALID,
    input  logic                  s1_ARREADY,
    input  logic [ID_WIDTH-1:0]   s1_RID,
    input  logic [DATA_WIDTH-1:0] s1_RDATA,
    input  logic [1:0]            s1_RRESP,
    input  logic                  s1_RLAST,
    input  logic [USER_WIDTH-1:0] s1_RUSER,
    input  logic                  s1_RVALID,
    output logic                  s1_RREADY
`ifdef AXI_MUX_R_STATS_EN
   ,output logic [31:0]           stat_rd_txn,
    output logic [31:0]           stat_rd_decerr
`endif
);

    rd_state_e state_q, state_d;

    logic [ID_WIDTH-1:0]   ar_id_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [7:0]            ar_len_q;
    logic [2:0]            ar_size_q;
    logic [1:0]            ar_burst_q;
    logic [USER_WIDTH-1:0] ar_user_q;
    logic                  sel_q;

    logic hit0, hit1, mapped, ar_hs;

    logic [ID_WIDTH-1:0]   err_rid;
    logic [DATA_WIDTH-1:0] err_rdata;
    logic [1:0]            err_rresp;
    logic                  err_rlast;
    logic [USER_WIDTH-1:0] err_ruser;
    logic                  err_rvalid;
    logic                  err_done;

    // s0 takes priority when regions overlap
    assign hit0   = (m_ARADDR & S0_MASK) == S0_BASE;
    assign hit1   = (m_ARADDR & S1_MASK) == S1_BASE;
    assign mapped = hit0 || hit1;
    assign ar_hs  = (state_q == IDLE) && m_ARVALID;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            ar_user_q  <= '0;
            sel_q      <= 1'b0;
        end else if (ar_hs) begin
            ar_id_q    <= m_ARID;
            ar_addr_q  <= m_ARADDR;
            ar_len_q   <= m_ARLEN;
            ar_size_q  <= m_ARSIZE;
            ar_burst_q <= m_ARBURST;
            ar_user_q  <= m_ARUSER;
            sel_q      <= !hit0;
        end
    end

    axi_r_decerr_gen #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) u_decerr (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .start  (ar_hs && !mapped),
        .id     (m_ARID),
        .len    (m_ARLEN),
        .rready (m_RREADY),
        .rid    (err_rid),
        .rdata  (err_rdata),
        .rresp  (err_rresp),
        .rlast  (err_rlast),
        .ruser  (err_ruser),
        .rvalid (err_rvalid),
        .done   (err_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (m_ARVALID) state_d = mapped ? ISSUE : ERR;
            ISSUE: if (sel_q ? s1_ARREADY : s0_ARREADY) state_d = DATA;
            DATA:  if (m_RVALID && m_RREADY && m_RLAST) state_d = IDLE;
            ERR:   if (err_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_ARREADY  = 1'b0;
        m_RID      = '0;
        m_RDATA    = '0;
        m_RRESP    = RESP_OKAY;
        m_RLAST    = 1'b0;
        m_RUSER    = '0;
        m_RVALID   = 1'b0;
        s0_ARVALID = 1'b0;
        s1_ARVALID = 1'b0;
        s0_RREADY  = 1'b0;
        s1_RREADY  = 1'b0;
        s0_ARID    = ar_id_q;
        s0_ARADDR  = ar_addr_q;
        s0_ARLEN   = ar_len_q;
        s0_ARSIZE  = ar_size_q;
        s0_ARBURST = ar_burst_q;
        s0_ARUSER  = ar_user_q;
        s1_ARID    = ar_id_q;
        s1_ARADDR  = ar_addr_q;
        s1_ARLEN   = ar_len_q;
        s1_ARSIZE  = ar_size_q;
        s1_ARBURST = ar_burst_q;
        s1_ARUSER  = ar_user_q;
        case (state_q)
            IDLE:  m_ARREADY = 1'b1;
            ISSUE: begin
                s0_ARVALID = !sel_q;
                s1_ARVALID = sel_q;
            end
            DATA: begin
                if (sel_q) begin
                    m_RID     = s1_RID;
                    m_RDATA   = s1_RDATA;
                    m_RRESP   = s1_RRESP;
                    m_RLAST   = s1_RLAST;
                    m_RUSER   = s1_RUSER;
                    m_RVALID  = s1_RVALID;
                    s1_RREADY = m_RREADY;
                end else begin
                    m_RID     = s0_RID;
                    m_RDATA   = s0_RDATA;
                    m_RRESP   = s0_RRESP;
                    m_RLAST   = s0_RLAST;
                    m_RUSER   = s0_RUSER;
                    m_RVALID  = s0_RVALID;
                    s0_RREADY = m_RREADY;
                end
            end
            ERR: begin
                m_RID    = err_rid;
                m_RDATA  = err_rdata;
                m_RRESP  = err_rresp;
                m_RLAST  = err_rlast;
                m_RUSER  = err_ruser;
                m_RVALID = err_rvalid;
            end
            default: ;
        endcase
        // Reset is synchronous, so outputs are forced low for the reset cycle itself
        if (ARESET) begin
            m_ARREADY  = 1'b0;
            m_RID      = '0;
            m_RDATA    = '0;
            m_RRESP    = RESP_OKAY;
            m_RLAST    = 1'b0;
            m_RUSER    = '0;
            m_RVALID   = 1'b0;
            s0_ARVALID = 1'b0;
            s1_ARVALID = 1'b0;
            s0_RREADY  = 1'b0;
            s1_RREADY  = 1'b0;
            s0_ARID    = '0;
            s0_ARADDR  = '0;
            s0_ARLEN   = '0;
            s0_ARSIZE  = '0;
            s0_ARBURST = '0;
            s0_ARUSER  = '0;
            s1_ARID    = '0;
            s1_ARADDR  = '0;
            s1_ARLEN   = '0;
            s1_ARSIZE  = '0;
            s1_ARBURST = '0;
            s1_ARUSER  = '0;
        end
    end

`ifdef AXI_MUX_R_STATS_EN
    logic [31:0] txn_q, decerr_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            txn_q    <= '0;
            decerr_q <= '0;
        end else if (ar_hs) begin
            if (txn_q != 32'hFFFF_FFFF) txn_q <= txn_q + 32'd1;
            if (!mapped && decerr_q != 32'hFFFF_FFFF) decerr_q <= decerr_q + 32'd1;
        end
    end

    assign stat_rd_txn    = ARESET ? 32'd0 : txn_q;
    assign stat_rd_decerr = ARESET ? 32'd0 : decerr_q;
`endif

endmodule
